// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: bubble encoding, boot address, FSM states
// and the target alignment helper used by the PC generator.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;   // addi x0,x0,0
    localparam logic [31:0] RESET_PC = 32'h4000_0000;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_STALL = 2'd2
    } fetch_state_e;

    // Word-align a jump target; bit0 is dropped as JALR requires, bit1 is
    // reported separately as a misalignment.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's control inputs, IMEM port and decode-facing
// outputs. The master view belongs to the fetch stage itself.
interface fetch_stage_if;

    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic [31:0] inst_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        misalign_err;
    logic [31:0] fetch_cnt;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, imem_en, inst_d, pc_d, valid_d, misalign_err, fetch_cnt
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, imem_en, inst_d, pc_d, valid_d, misalign_err, fetch_cnt
    );

endinterface

// File: rtl/fetch_pc_gen.sv
// Next fetch address selection: redirect beats stall beats boot beats the
// sequential increment. Also flags a redirect target with bit1 set.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    input  logic        boot_i,
    input  logic [31:0] pc_i,
    output logic [31:0] nxt_o,
    output logic        misalign_o
);
    import fetch_stage_pkg::*;

    // Priority mux for the address issued to IMEM this cycle.
    always_comb begin
        nxt_o = pc_i + 32'd4;
        if (redirect_i) begin
            nxt_o = align_word(redirect_pc_i);
        end else if (stall_i) begin
            nxt_o = pc_i;
        end else if (boot_i) begin
            nxt_o = RESET_PC;
        end
    end

    assign misalign_o = redirect_i & redirect_pc_i[1];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, drives the synchronous IMEM,
// inserts bubbles at boot and on redirects, holds the instruction through
// stalls and counts instructions accepted by decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    import fetch_stage_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  hold_q, hold_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         misalign_q;
    logic [31:0]  nxt;
    logic         misalign_set;
    logic [31:0]  inst_c;
    logic         valid_c;

    fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .redirect_i    (bus.redirect),
        .redirect_pc_i (bus.redirect_pc),
        .stall_i       (bus.stall),
        .boot_i        (state_q == FETCH_BOOT),
        .pc_i          (pc_q),
        .nxt_o         (nxt),
        .misalign_o    (misalign_set)
    );

    // FSM next state, hold capture and the instruction presented to decode.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        inst_c  = NOP_INST;
        valid_c = 1'b0;
        case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
                inst_c  = bus.imem_rdata;
                valid_c = 1'b1;
                if (bus.stall) begin
                    state_d = FETCH_STALL;
                    hold_d  = bus.imem_rdata;
                end
            end
            FETCH_STALL: begin
                inst_c  = hold_q;
                valid_c = 1'b1;
                if (!bus.stall) begin
                    state_d = FETCH_RUN;
                end
            end
            default: begin
                state_d = FETCH_BOOT;
            end
        endcase
        // A redirect kills the wrong-path instruction in the same cycle.
        if (bus.redirect) begin
            state_d = FETCH_RUN;
            hold_d  = hold_q;
            inst_c  = NOP_INST;
            valid_c = 1'b0;
        end
    end

    // Handoff counter: advances only when decode actually takes the instruction.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_c && !bus.stall && !bus.redirect) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // State, PC, hold, sticky error and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_BOOT;
            pc_q       <= RESET_PC;
            hold_q     <= NOP_INST;
            misalign_q <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= nxt;
            hold_q     <= hold_d;
            misalign_q <= misalign_q | misalign_set;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.imem_addr    = nxt;
    assign bus.imem_en      = !(bus.stall && !bus.redirect);
    assign bus.inst_d       = inst_c;
    assign bus.pc_d         = pc_q;
    assign bus.valid_d      = valid_c;
    assign bus.misalign_err = misalign_q;
    assign bus.fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage with an abstract program-order
// model: a "next PC to deliver" pointer, a handoff count and a sticky error.
module tb_fetch_stage;

    localparam logic [31:0] T_RESET_PC = 32'h4000_0000;
    localparam logic [31:0] T_NOP      = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(T_RESET_PC), .NOP_INST(T_NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Synchronous-read instruction memory, holds its output when disabled.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_mis;
    logic        pend_mis;
    logic        prev_hold;
    logic [31:0] snap_inst, snap_pc, snap_cnt;
    logic        snap_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every instruction decode accepts is matched against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.valid_d === 1'b1 && !bus.stall && !bus.redirect) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_handoff: got pc %08h expected no handoff", bus.pc_d);
            end else begin
                e = sb.pop_front();
                $display("handoff pc=%08h inst=%08h cnt=%0d", bus.pc_d, bus.inst_d, bus.fetch_cnt);
                chk("handoff_pc",   bus.pc_d,      e.pc);
                chk("handoff_inst", bus.inst_d,    e.inst);
                chk("handoff_cnt",  bus.fetch_cnt, e.cnt);
            end
        end
    end

    task automatic model_init();
        m_pc      = T_RESET_PC;
        m_cnt     = 32'd0;
        m_mis     = 1'b0;
        pend_mis  = 1'b0;
        prev_hold = 1'b0;
    endtask

    // Release reset and check the single boot bubble.
    task automatic do_boot();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_valid", {31'd0, bus.valid_d}, 32'd0);
        chk("boot_inst",  bus.inst_d,    T_NOP);
        chk("boot_addr",  bus.imem_addr, T_RESET_PC);
        chk("boot_en",    {31'd0, bus.imem_en}, 32'd1);
        model_init();
    endtask

    // One pipeline cycle with the given stall/redirect inputs.
    task automatic drive_cycle(input logic r, input logic s, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        if (pend_mis) m_mis = 1'b1;
        pend_mis        = 1'b0;
        bus.stall       = s;
        bus.redirect    = r;
        bus.redirect_pc = tgt;
        #1;
        chk("imem_en",      {31'd0, bus.imem_en}, (s && !r) ? 32'd0 : 32'd1);
        chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_mis});
        chk("fetch_cnt",    bus.fetch_cnt, m_cnt);
        if (r) begin
            chk("redir_valid", {31'd0, bus.valid_d}, 32'd0);
            chk("redir_inst",  bus.inst_d,    T_NOP);
            chk("redir_addr",  bus.imem_addr, {tgt[31:2], 2'b00});
        end else begin
            chk("valid_d",   {31'd0, bus.valid_d}, 32'd1);
            chk("pc_d",      bus.pc_d,      m_pc);
            chk("inst_d",    bus.inst_d,    mem_word(m_pc));
            chk("imem_addr", bus.imem_addr, s ? m_pc : m_pc + 32'd4);
            if (prev_hold) begin
                chk("stall_inst",  bus.inst_d,    snap_inst);
                chk("stall_pc",    bus.pc_d,      snap_pc);
                chk("stall_valid", {31'd0, bus.valid_d}, {31'd0, snap_valid});
                chk("stall_cnt",   bus.fetch_cnt, snap_cnt);
            end
        end
        snap_inst  = bus.inst_d;
        snap_pc    = bus.pc_d;
        snap_valid = bus.valid_d;
        snap_cnt   = bus.fetch_cnt;
        // Program-order model update
        if (r) begin
            m_pc = {tgt[31:2], 2'b00};
            if (tgt[1]) pend_mis = 1'b1;
        end else if (!s) begin
            sb.push_back('{pc: m_pc, inst: mem_word(m_pc), cnt: m_cnt});
            m_cnt = m_cnt + 32'd1;
            m_pc  = m_pc + 32'd4;
        end
        prev_hold = s && !r;
    endtask

    task automatic random_cycles(input int n);
        logic [31:0] tgt;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0)
                tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                tgt = 32'h4000_0000 | 32'($urandom_range(0, 32'hFFFF));
            drive_cycle($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, tgt);
        end
    endtask

    initial begin
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        model_init();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, bus.valid_d}, 32'd0);
        chk("rst_inst",  bus.inst_d,    T_NOP);
        chk("rst_pc",    bus.pc_d,      T_RESET_PC);
        chk("rst_addr",  bus.imem_addr, T_RESET_PC);
        chk("rst_en",    {31'd0, bus.imem_en}, 32'd1);
        chk("rst_cnt",   bus.fetch_cnt, 32'd0);
        chk("rst_mis",   {31'd0, bus.misalign_err}, 32'd0);
        do_boot();

        // Straight-line fetch, a 3-cycle stall, then redirects with bit0/bit1.
        repeat (3) drive_cycle(1'b0, 1'b0, 32'd0);
        repeat (3) drive_cycle(1'b0, 1'b1, 32'd0);
        repeat (2) drive_cycle(1'b0, 1'b0, 32'd0);
        drive_cycle(1'b1, 1'b0, 32'h4000_0100);
        drive_cycle(1'b0, 1'b0, 32'd0);
        drive_cycle(1'b1, 1'b0, 32'h4000_0201);
        repeat (2) drive_cycle(1'b0, 1'b0, 32'd0);
        repeat (2) drive_cycle(1'b0, 1'b1, 32'd0);
        drive_cycle(1'b1, 1'b1, 32'h4000_0300);
        drive_cycle(1'b0, 1'b0, 32'd0);
        drive_cycle(1'b1, 1'b0, 32'h4000_0102);
        repeat (3) drive_cycle(1'b0, 1'b0, 32'd0);

        random_cycles(400);

        // Reset pulsed in the middle of a stall.
        repeat (2) drive_cycle(1'b0, 1'b1, 32'd0);
        #1;
        rst_n     = 1'b0;
        bus.stall = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, bus.valid_d}, 32'd0);
        chk("midrst_inst",  bus.inst_d,    T_NOP);
        chk("midrst_pc",    bus.pc_d,      T_RESET_PC);
        chk("midrst_addr",  bus.imem_addr, T_RESET_PC);
        chk("midrst_en",    {31'd0, bus.imem_en}, 32'd1);
        chk("midrst_cnt",   bus.fetch_cnt, 32'd0);
        chk("midrst_mis",   {31'd0, bus.misalign_err}, 32'd0);
        chk("sb_drained",   32'(sb.size()), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        do_boot();
        random_cycles(150);

        @(posedge clk);
        @(negedge clk);
        chk("sb_final_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 3-stage RISC-V core, directly upstream of the control/decode path. It owns the fetch PC and drives the synchronous-read instruction memory. It presents each instruction with its PC and a valid flag to decode, and it inserts NOP bubbles after boot and on taken redirects. It also holds the current instruction stable while the pipeline is stalled, and counts instructions handed to decode.

## Interface
Parameters:
- RESET_PC, 32'h4000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hold fetch and decode outputs (hazard / data-memory wait)
- redirect  in  1  taken branch, JAL or JALR resolved in execute
- redirect_pc  in  32  redirect target
- imem_addr  out  32  byte address issued to IMEM this cycle
- imem_en  out  1  IMEM read enable
- imem_rdata  in  32  IMEM data for the address issued in the previous cycle
- inst_d  out  32  instruction to decode (Opcode = inst_d[6:0], funct3 = [14:12], bit30)
- pc_d  out  32  PC of inst_d
- valid_d  out  1  inst_d is a real instruction
- misalign_err  out  1  sticky: redirect target had bit1 set
- fetch_cnt  out  32  count of instructions accepted by decode

## Operation
- Registers: pc_f (32), state (BOOT/RUN/STALL), hold_inst (32), misalign_err, fetch_cnt.
- Next address nxt, in priority order:
  - redirect: {redirect_pc[31:2],2'b00}
  - stall: pc_f
  - BOOT: RESET_PC
  - otherwise: pc_f+4 (mod 2^32, wraps silently)
- imem_addr = nxt, combinational. pc_f <= nxt every cycle.
- imem_en = 0 only when state will be or remains STALL (stall && !redirect); otherwise 1.
- pc_d = pc_f.
- inst_d source:
  - redirect: NOP_INST, valid_d=0. The wrong-path instruction is killed combinationally in the same cycle.
  - BOOT: NOP_INST, valid_d=0.
  - STALL: hold_inst, valid_d=1.
  - RUN: imem_rdata, valid_d=1.
- FSM transitions:
  - BOOT -> RUN: next cycle, unconditionally, unless redirect (-> RUN anyway).
  - RUN & stall & !redirect -> STALL: hold_inst <= imem_rdata.
  - STALL & !stall -> RUN. inst_d still comes from hold_inst in this release cycle.
  - any & redirect -> RUN. Redirect beats stall; hold_inst is discarded.
- misalign_err is set when redirect && redirect_pc[1]. It clears only on reset. Bit0 is silently dropped (JALR semantics).
- fetch_cnt increments when valid_d && !stall && !redirect. It wraps at 2^32.

## Timing
- Reset (rst_n low, async):
  - pc_f = RESET_PC, state = BOOT, hold_inst = NOP_INST
  - misalign_err = 0, fetch_cnt = 0
  - outputs: valid_d = 0, inst_d = NOP_INST, pc_d = RESET_PC, imem_addr = RESET_PC, imem_en = 1
- First valid instruction: the second rising edge after rst_n deasserts. Boot costs one bubble.
- IMEM latency is 1 cycle. In steady state, inst_d at cycle t is the instruction at pc_f, which was issued at t-1.
- Redirect penalty is 1 bubble. Redirect at cycle t: inst_d = NOP at t, and the target instruction appears at t+1.
- Stall: all outputs are bit-stable from the first stall cycle through the release cycle. In the cycle after release, inst_d = instruction at pc_f+4.
- Reset asserted mid-stall or mid-redirect: returns to the BOOT values immediately, with no completed handoff.

## Structure
- Shared defines file gains: NOP_INST, RESET_PC, and the FETCH_BOOT/FETCH_RUN/FETCH_STALL 2-bit encodings.
- One sub-module, fetch_pc_gen: the combinational nxt priority mux, target alignment and misalign detect. The FSM, hold register and counter stay in fetch_stage.

## Test plan
- Reset release, no stall: imem_addr 0x40000000 twice; valid_d=0 for 1 cycle, then pc_d 0x40000000, 0x40000004, 0x40000008; fetch_cnt=3 after three handoffs.
- Stall 3 cycles while inst_d=0x00500093 at pc 0x40000008: inst_d/pc_d/valid_d stable for 4 cycles, imem_en=0 for 3; next cycle pc_d=0x4000000C; fetch_cnt does not advance during stall.
- Redirect to 0x40000100 at pc_d 0x40000010: same cycle inst_d=0x00000013, valid_d=0, imem_addr=0x40000100; next cycle pc_d=0x40000100, valid_d=1.
- Redirect and stall simultaneously while in STALL: redirect wins; next cycle state RUN, pc_d=target, hold instruction never re-presented.
- Redirect to 0x40000102: misalign_err=1 and stays 1; imem_addr=0x40000100. Redirect to 0x40000201: misalign_err unaffected by bit0, imem_addr=0x40000200.
- rst_n pulsed low mid-stall: outputs return to reset values asynchronously; fetch_cnt=0; BOOT bubble repeats after release.
